// File: rtl/gate_chk_pkg.sv
// ----------------------------------------------------------------------------
// gate_chk_pkg
// Shared definitions for the 2-input gate truth-table checker: FSM state
// encoding, number of input vectors swept, and reference truth tables for
// the common 2-input gates (bit i = Z for input vector i = {A,B}).
// ----------------------------------------------------------------------------
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int NUM_VECTORS = 4;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_table_checker_settle_counter.sv
// ----------------------------------------------------------------------------
// settle_counter
// 8-bit loadable down-counter that times how long each stimulus vector is
// held before the gate output is sampled.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset (count -> 0)
//   i_load      load i_load_val (has priority over i_dec)
//   i_load_val  value to load
//   i_dec       decrement by one
//   o_value     current count
//   o_expire    high when the count is 1 (last settle cycle)
// ----------------------------------------------------------------------------
module settle_counter (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_dec,
   output logic [7:0] o_value,
   output logic       o_expire
);

   logic [7:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_count <= 8'd0;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_dec)
         r_count <= r_count - 8'd1;
   end

   assign o_value  = r_count;
   assign o_expire = (r_count == 8'd1);

endmodule

// File: rtl/gate_truth_table_checker.sv
// ----------------------------------------------------------------------------
// gate_truth_table_checker
// Stimulus/response checker for a 2-input combinational gate. On start it
// drives the four {A,B} vectors in order, holds each for SETTLE_CYCLES
// cycles plus one sample cycle, captures Z into a 4-bit truth table and
// compares it with EXPECTED_TT.
//
// Parameters:
//   EXPECTED_TT    expected truth table, bit i = Z for {A,B} = i
//   SETTLE_CYCLES  settle cycles per vector before sampling (1..255)
//
// Ports:
//   i_clk, i_rst      clock / synchronous active-high reset
//   i_start           run request, only looked at in IDLE
//   o_drive_a/b       registered stimulus to the gate under test
//   i_sense_z         gate output
//   o_busy            high from start acceptance until DONE is left
//   o_done            one-cycle pulse, results valid
//   o_pass            truth table matched (held until next start)
//   o_truth_table     captured Z per vector (held until next start)
//   o_fail_mask       truth_table ^ EXPECTED_TT (held until next start)
//   o_err_count       saturating count of failing runs, only present when
//                     GATE_CHECK_ERRCNT_EN is defined
//
// Optional feature macro: GATE_CHECK_ERRCNT_EN
// ----------------------------------------------------------------------------
module gate_truth_table_checker
   import gate_chk_pkg::*;
#(
   parameter logic [3:0] EXPECTED_TT   = TT_AND,
   parameter int         SETTLE_CYCLES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   output logic       o_drive_a,
   output logic       o_drive_b,
   input  logic       i_sense_z,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [3:0] o_truth_table,
   output logic [3:0] o_fail_mask
`ifdef GATE_CHECK_ERRCNT_EN
   ,
   output logic [7:0] o_err_count
`endif
);

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
   localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

   // A zero settle time would never expire the counter; refuse to build.
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $fatal(1, "gate_truth_table_checker: SETTLE_CYCLES=%0d outside 1..255",
             SETTLE_CYCLES);
   end

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_idx;
   logic [1:0] r_drive;       // {A,B}
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [3:0] r_tt;
   logic [3:0] r_fail_mask;

   logic       w_load;
   logic       w_dec;
   logic       w_expire;
   logic [7:0] w_settle_val;
   logic [3:0] w_tt_capt;

   settle_counter u_settle (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_load_val (SETTLE_LOAD),
      .i_dec      (w_dec),
      .o_value    (w_settle_val),
      .o_expire   (w_expire)
   );

   // Truth table with the current vector's response merged in, so pass and
   // fail_mask can be registered on the same edge that enters DONE.
   always_comb begin
      w_tt_capt        = r_tt;
      w_tt_capt[r_idx] = i_sense_z;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_dec  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next = SETTLE;
               w_load = 1'b1;
            end
         end
         SETTLE: begin
            if (w_expire)
               w_next = SAMPLE;
            else if (w_settle_val != 8'd0)
               w_dec = 1'b1;
         end
         SAMPLE: begin
            if (r_idx == LAST_IDX) begin
               w_next = DONE;
            end else begin
               w_next = SETTLE;
               w_load = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_idx       <= 2'd0;
         r_drive     <= 2'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_tt        <= 4'd0;
         r_fail_mask <= 4'd0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == SAMPLE) && (r_idx == LAST_IDX);
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_idx       <= 2'd0;
                  r_drive     <= 2'd0;
                  r_busy      <= 1'b1;
                  r_pass      <= 1'b0;
                  r_tt        <= 4'd0;
                  r_fail_mask <= 4'd0;
               end
            end
            SAMPLE: begin
               r_tt <= w_tt_capt;
               if (r_idx == LAST_IDX) begin
                  r_pass      <= (w_tt_capt == EXPECTED_TT);
                  r_fail_mask <= w_tt_capt ^ EXPECTED_TT;
               end else begin
                  r_idx   <= r_idx + 2'd1;
                  r_drive <= r_idx + 2'd1;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_drive <= 2'd0;
            end
            default: ;
         endcase
      end
   end

`ifdef GATE_CHECK_ERRCNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_err_count <= 8'd0;
      else if (r_state == DONE && !r_pass && r_err_count != 8'hFF)
         r_err_count <= r_err_count + 8'd1;
   end

   assign o_err_count = r_err_count;
`endif

   assign o_drive_a     = r_drive[1];
   assign o_drive_b     = r_drive[0];
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_pass        = r_pass;
   assign o_truth_table = r_tt;
   assign o_fail_mask   = r_fail_mask;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// ----------------------------------------------------------------------------
// tb_gate_truth_table_checker
// Five checker instances share one clock/reset:
//   0: AND2 built from two NAND2, default parameters
//   1: NAND2, expecting AND
//   2: NAND2, expecting NAND
//   3: Z tied low, default parameters
//   4: AND2 from NAND2, SETTLE_CYCLES=1 (own start)
// Expected results per run are queued when start is driven and compared
// when the instance pulses done.
// ----------------------------------------------------------------------------
module tb_gate_truth_table_checker;
   import gate_chk_pkg::*;

   typedef struct {
      logic [3:0] tt;
      logic       pass;
      logic [3:0] fm;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic g_start;
   logic s1_start;

   logic [4:0]      da, db, busy, done, pass, sz;
   logic [4:0][3:0] tt, fm;
`ifdef GATE_CHECK_ERRCNT_EN
   logic [4:0][7:0] ec;
`endif

   int n_vec = 0;
   int n_err = 0;
   int fails [5];
   exp_t q0[$], q1[$], q2[$], q3[$], q4[$];

   always #5 clk = ~clk;

   // Gate models driven by each instance's own stimulus
   assign sz[0] = ~(~(da[0] & db[0]) & ~(da[0] & db[0]));
   assign sz[1] = ~(da[1] & db[1]);
   assign sz[2] = ~(da[2] & db[2]);
   assign sz[3] = 1'b0;
   assign sz[4] = ~(~(da[4] & db[4]) & ~(da[4] & db[4]));

   gate_truth_table_checker #(.EXPECTED_TT(4'b1000)) u_and (
      .i_clk(clk), .i_rst(rst), .i_start(g_start),
      .o_drive_a(da[0]), .o_drive_b(db[0]), .i_sense_z(sz[0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
      .o_truth_table(tt[0]), .o_fail_mask(fm[0])
`ifdef GATE_CHECK_ERRCNT_EN
      , .o_err_count(ec[0])
`endif
   );
   gate_truth_table_checker #(.EXPECTED_TT(4'b1000)) u_nand_x_and (
      .i_clk(clk), .i_rst(rst), .i_start(g_start),
      .o_drive_a(da[1]), .o_drive_b(db[1]), .i_sense_z(sz[1]),
      .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
      .o_truth_table(tt[1]), .o_fail_mask(fm[1])
`ifdef GATE_CHECK_ERRCNT_EN
      , .o_err_count(ec[1])
`endif
   );
   gate_truth_table_checker #(.EXPECTED_TT(4'b0111)) u_nand_x_nand (
      .i_clk(clk), .i_rst(rst), .i_start(g_start),
      .o_drive_a(da[2]), .o_drive_b(db[2]), .i_sense_z(sz[2]),
      .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]),
      .o_truth_table(tt[2]), .o_fail_mask(fm[2])
`ifdef GATE_CHECK_ERRCNT_EN
      , .o_err_count(ec[2])
`endif
   );
   gate_truth_table_checker u_zero (
      .i_clk(clk), .i_rst(rst), .i_start(g_start),
      .o_drive_a(da[3]), .o_drive_b(db[3]), .i_sense_z(sz[3]),
      .o_busy(busy[3]), .o_done(done[3]), .o_pass(pass[3]),
      .o_truth_table(tt[3]), .o_fail_mask(fm[3])
`ifdef GATE_CHECK_ERRCNT_EN
      , .o_err_count(ec[3])
`endif
   );
   gate_truth_table_checker #(.SETTLE_CYCLES(1)) u_s1 (
      .i_clk(clk), .i_rst(rst), .i_start(s1_start),
      .o_drive_a(da[4]), .o_drive_b(db[4]), .i_sense_z(sz[4]),
      .o_busy(busy[4]), .o_done(done[4]), .o_pass(pass[4]),
      .o_truth_table(tt[4]), .o_fail_mask(fm[4])
`ifdef GATE_CHECK_ERRCNT_EN
      , .o_err_count(ec[4])
`endif
   );

   task automatic chk(input string tag, input int idx,
                      input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s[%0d]: observed %0h, expected %0h", tag, idx, obs, exp_v);
      end
   endtask

   // kind: 0 = AND, 1 = NAND, 2 = stuck-at-0
   function automatic logic [3:0] model_tt(input int kind);
      logic [3:0] t;
      logic       a, b;
      t = 4'd0;
      for (int v = 0; v < 4; v++) begin
         a = v[1];
         b = v[0];
         case (kind)
            0:       t[v] = a & b;
            1:       t[v] = ~(a & b);
            default: t[v] = 1'b0;
         endcase
      end
      return t;
   endfunction

   task automatic push_exp(input int i);
      exp_t       e;
      logic [3:0] ref_tt;
      case (i)
         1:       begin e.tt = model_tt(1); ref_tt = 4'b1000; end
         2:       begin e.tt = model_tt(1); ref_tt = 4'b0111; end
         3:       begin e.tt = model_tt(2); ref_tt = 4'b1000; end
         default: begin e.tt = model_tt(0); ref_tt = 4'b1000; end
      endcase
      e.pass = (e.tt == ref_tt);
      e.fm   = e.tt ^ ref_tt;
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         3: q3.push_back(e);
         default: q4.push_back(e);
      endcase
   endtask

   function automatic int q_size(input int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         3: return q3.size();
         default: return q4.size();
      endcase
   endfunction

   task automatic pop_check(input int i);
      exp_t e;
      int   n;
      n = q_size(i);
      chk("done_expected", i, 32'(n != 0), 32'd1);
      if (n == 0) return;
      case (i)
         0: e = q0.pop_front();
         1: e = q1.pop_front();
         2: e = q2.pop_front();
         3: e = q3.pop_front();
         default: e = q4.pop_front();
      endcase
      chk("truth_table", i, 32'(tt[i]), 32'(e.tt));
      chk("pass", i, 32'(pass[i]), 32'(e.pass));
      chk("fail_mask", i, 32'(fm[i]), 32'(e.fm));
      if (!e.pass) fails[i]++;
   endtask

   // One clock: sample at the falling edge and retire any done pulses.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 5; i++)
         if (done[i]) pop_check(i);
   endtask

   task automatic check_errcnt();
`ifdef GATE_CHECK_ERRCNT_EN
      for (int i = 0; i < 5; i++)
         chk("err_count", i, 32'(ec[i]), (fails[i] > 255) ? 32'd255 : 32'(fails[i]));
`endif
   endtask

   // One run of instances 0..3 (settle 2). detail adds per-cycle checks on
   // instance 0's stimulus/handshake.
   task automatic run_group(input bit detail);
      logic [1:0] ev;
      for (int i = 0; i < 4; i++) push_exp(i);
      g_start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 1) begin
            g_start = 1'b0;
            for (int i = 0; i < 4; i++) begin
               chk("clr_tt", i, 32'(tt[i]), 32'd0);
               chk("clr_pass", i, 32'(pass[i]), 32'd0);
               chk("clr_fm", i, 32'(fm[i]), 32'd0);
            end
         end
         if (detail) begin
            ev = (c <= 12) ? 2'((c - 1) / 3) : ((c == 13) ? 2'd3 : 2'd0);
            chk("drive_ab", c, 32'({da[0], db[0]}), 32'(ev));
            chk("busy", c, 32'(busy[0]), 32'(c <= 13));
            chk("done", c, 32'(done[0]), 32'(c == 13));
         end
      end
      check_errcnt();
   endtask

   task automatic clear_model();
      q0.delete(); q1.delete(); q2.delete(); q3.delete(); q4.delete();
      for (int i = 0; i < 5; i++) fails[i] = 0;
   endtask

   initial begin
      rst      = 1'b1;
      g_start  = 1'b0;
      s1_start = 1'b0;
      clear_model();
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      for (int i = 0; i < 5; i++) begin
         chk("rst_drive", i, 32'({da[i], db[i]}), 32'd0);
         chk("rst_busy", i, 32'(busy[i]), 32'd0);
         chk("rst_done", i, 32'(done[i]), 32'd0);
         chk("rst_pass", i, 32'(pass[i]), 32'd0);
         chk("rst_tt", i, 32'(tt[i]), 32'd0);
         chk("rst_fm", i, 32'(fm[i]), 32'd0);
      end
      check_errcnt();

      // AND/NAND/stuck-0 sweeps, then a rerun to see results cleared on start
      run_group(1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_tt", i, 32'(tt[i]), 32'(i == 3 ? 4'd0 : (i == 0 ? 4'b1000 : 4'b0111)));
      end
      run_group(1'b0);

      // Held start on the settle-1 instance: runs back to back every 10 cycles
      for (int k = 0; k < 4; k++) push_exp(4);
      s1_start = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         step();
         if (c == 40) s1_start = 1'b0;
         chk("s1_done", c, 32'(done[4]), 32'((c % 10 == 9) && (c < 40)));
         chk("s1_busy", c, 32'(busy[4]), 32'((c < 40) && (c % 10 != 0)));
      end
      chk("s1_q_empty", 4, 32'(q_size(4)), 32'd0);

      // Reset in the middle of a run
      for (int i = 0; i < 4; i++) push_exp(i);
      g_start = 1'b1;
      step();
      g_start = 1'b0;
      for (int c = 2; c <= 5; c++) step();
      chk("mid_drive", 0, 32'({da[0], db[0]}), 32'd1);
      chk("mid_busy", 0, 32'(busy[0]), 32'd1);
      chk("mid_tt", 1, 32'(tt[1]), 32'b0001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_model();
      for (int i = 0; i < 4; i++) begin
         chk("abort_drive", i, 32'({da[i], db[i]}), 32'd0);
         chk("abort_busy", i, 32'(busy[i]), 32'd0);
         chk("abort_tt", i, 32'(tt[i]), 32'd0);
         chk("abort_done", i, 32'(done[i]), 32'd0);
      end
      check_errcnt();
      // any done here has an empty queue and is reported by pop_check
      for (int c = 0; c < 15; c++) step();
      run_group(1'b1);

`ifdef GATE_CHECK_ERRCNT_EN
      // Failing instances accumulate until the counter saturates
      for (int r = 0; r < 300; r++) run_group(1'b0);
      chk("errcnt_sat", 1, 32'(ec[1]), 32'd255);
`endif

      for (int i = 0; i < 5; i++)
         chk("q_empty", i, 32'(q_size(i)), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
